commit_checker: RTL and testbench
=================================

# commit_checker

Synthesizable, parametrised self-checking retire monitor for the RV32I core. It compares each retired instruction (pc, register-write enable, destination, write data) against an expected trace held in an internal memory, and reports pass, fail or timeout. Failures are reported with the failing index, field mask and captured values. It sits beside `Top` on the retire bus in simulation and FPGA bring-up, and replaces hand-written per-cycle assertions.

## Interface
- `XLEN`, 32: data and pc width.
- `DEPTH`, 64: expected-trace entries; power of two, at least 2.
- `TIMEOUT`, 16: maximum consecutive RUN cycles without `retire_valid`.
- `STRICT`, 0: 1 means `rd` and `wdata` are also compared when the expected `we` is 0.
- `CHECK_PC`, 1: 0 excludes pc from the comparison.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-low.
- `load_we` in 1: trace write strobe.
- `load_addr` in $clog2(DEPTH): trace write index.
- `load_pc` / `load_rd` / `load_wdata` / `load_rwe` in XLEN/5/XLEN/1: expected entry fields.
- `exp_count` in $clog2(DEPTH)+1: number of entries to check; sampled on `start`.
- `start` in 1: begin a check run.
- `retire_valid` in 1: an instruction retires this cycle.
- `retire_pc` / `retire_rd` / `retire_wdata` / `retire_we` in XLEN/5/XLEN/1: retire bus.
- `busy` out 1: in RUN.
- `done` out 1: in PASS or FAIL; held until reset or a new `start`.
- `pass`, `fail`, `timeout` out 1: result flags.
- `matched` out $clog2(DEPTH)+1: count of entries matched so far.
- `fail_index` out $clog2(DEPTH): index of the first mismatch.
- `fail_mask` out 4: bit0 pc, bit1 we, bit2 rd, bit3 wdata.
- `fail_got` / `fail_exp` out XLEN: retired and expected wdata at the mismatch.

## Operation
- FSM states: IDLE, RUN, PASS, FAIL.
- IDLE with `start`:
  - Latch `min(exp_count, DEPTH)`, clear `matched`, the timeout counter and all result fields.
  - Go to RUN, or to PASS if the latched count is 0.
- Loads are accepted in IDLE, PASS and FAIL; `load_we` in RUN is ignored.
- RUN, `retire_valid`=1: compare the retire bus with entry[`matched`].
  - `we` is always compared.
  - `pc` is compared iff `CHECK_PC`.
  - `rd` and `wdata` are compared iff the expected `we`=1 or `STRICT`=1.
  - All compared fields equal: `matched`++. If `matched`+1 equals the count, go to PASS.
  - Any difference: go to FAIL. Capture `fail_index`=`matched`, the mask bits of the differing fields, and `fail_got`/`fail_exp`.
- RUN, `retire_valid`=0: the timeout counter increments. When it reaches `TIMEOUT`, go to FAIL with `timeout`=1, `fail_mask`=0 and `fail_index`=`matched`. The counter clears on any valid retire.
- PASS/FAIL:
  - Retires are ignored.
  - `start` restarts as from IDLE; outputs clear on the transition edge.
- `start` in RUN is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE; every output 0. Trace memory contents are not reset, so a re-run after a mid-run reset needs no reload.
- All outputs are registered and change only on a `clk` rising edge, except on reset.
- Trace memory: registered write; combinational read at index `matched`.
- A load and `start` in the same IDLE cycle: the write is visible to the first comparison, which happens at the earliest on the next cycle.
- Latency:
  - The `start` edge sets `busy`=1.
  - The edge sampling the final matching retire sets `pass`=1, `done`=1, `busy`=0.
  - A mismatch sets `fail`/`done` on the edge that samples the mismatching retire.
- One comparison per cycle; back-to-back retires are supported with no stall.
- The `exp_count` clamp to DEPTH is applied only at `start`.

## Structure
- Package `commit_check_pkg` holds:
  - `state_t` enum (IDLE/RUN/PASS/FAIL).
  - `FM_PC`/`FM_WE`/`FM_RD`/`FM_WDATA` mask bit indices.
  - Packed `trace_entry_t` struct (pc, rwe, rd, wdata), parametrised by XLEN via a localparam width.
- Sub-module `trace_mem`: DEPTH×entry storage with a synchronous write port and an asynchronous read port. The FSM, comparator and counters stay in `commit_checker`.

## Test plan
- Basic pass:
  - Load {pc0,we1,x1,0x3E8}, {pc4,we1,x2,0x3C0}, {pc8,we0,x8,0x8}; count 3; start.
  - Drive matching retires → `pass`=1, `done`=1, `matched`=3 one edge after the third retire.
- Data mismatch: same trace, second retire with wdata 0x3C1 → `fail`=1, `fail_index`=1, `fail_mask`=4'b1000, `fail_got`=0x3C1, `fail_exp`=0x3C0.
- Store don't-care: third retire with rd=x0, wdata=0 (expected we=0).
  - `STRICT`=0 → pass.
  - `STRICT`=1 → fail with `fail_mask`=4'b1100 and `fail_index`=2.
- Timeout: `TIMEOUT`=4; start, then no `retire_valid` → `fail`=`timeout`=1, `fail_index`=0, on the 4th idle RUN edge.
- Reset mid-run: assert `rst` low after 2 matches → all outputs 0 immediately. Release, start again, replay 3 retires → pass, without reloading.
- Count boundaries:
  - `exp_count`=0 → `pass` on the edge after start.
  - `exp_count`=DEPTH+5 → DEPTH matching retires give pass, with `matched`=DEPTH.

Source files
------------

// File: rtl/commit_checker_pkg.sv
// commit_check_pkg: shared types for the retire-trace checker.
//   state_t        - checker FSM states
//   FM_*           - bit positions inside fail_mask
//   trace_entry_t  - one expected retire record as stored in trace memory
package commit_check_pkg;

  // Field width of pc/wdata inside a stored trace entry; must match the
  // XLEN the checker is built with.
  localparam int unsigned TRACE_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  localparam int unsigned FM_PC    = 0;
  localparam int unsigned FM_WE    = 1;
  localparam int unsigned FM_RD    = 2;
  localparam int unsigned FM_WDATA = 3;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic                  rwe;
    logic [4:0]            rd;
    logic [TRACE_XLEN-1:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/commit_checker_if.sv
// commit_checker_if: retire bus observed by commit_checker.
//   retire_valid - an instruction retires this cycle
//   retire_pc    - pc of the retiring instruction
//   retire_rd    - destination register
//   retire_wdata - register write data
//   retire_we    - register write enable
// master drives the bus (core / bench), slave observes it (checker).
interface commit_checker_if #(
  parameter int unsigned XLEN = 32
);
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc;
  logic [4:0]      retire_rd;
  logic [XLEN-1:0] retire_wdata;
  logic            retire_we;

  modport master (
    output retire_valid, retire_pc, retire_rd, retire_wdata, retire_we
  );

  modport slave (
    input retire_valid, retire_pc, retire_rd, retire_wdata, retire_we
  );
endinterface

// File: rtl/commit_checker_trace_mem.sv
// trace_mem: expected-trace storage, DEPTH entries of trace_entry_t.
//   clk    - write clock
//   we     - write strobe
//   waddr  - write index
//   wentry - entry to store
//   raddr  - read index (combinational read)
//   rentry - stored entry at raddr
// Contents are deliberately not reset so a re-run needs no reload.
module trace_mem
  import commit_check_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_entry_t             wentry,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_entry_t             rentry
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wentry;
  end

  assign rentry = mem[raddr];

endmodule

// File: rtl/commit_checker.sv
// commit_checker: compares each retired instruction against an expected
// trace and reports pass / fail / timeout.
//   clk, rst            - clock, asynchronous active-low reset
//   load_*              - trace write port (ignored while running)
//   exp_count, start    - entries to check (clamped to DEPTH), run trigger
//   rbus                - retire bus (slave modport)
//   busy/done/pass/fail/timeout - status flags, registered
//   matched             - entries matched so far
//   fail_index/fail_mask/fail_got/fail_exp - first-mismatch capture
module commit_checker
  import commit_check_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned TIMEOUT  = 16,
  parameter bit          STRICT   = 1'b0,
  parameter bit          CHECK_PC = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_pc,
  input  logic [4:0]               load_rd,
  input  logic [XLEN-1:0]          load_wdata,
  input  logic                     load_rwe,
  input  logic [$clog2(DEPTH):0]   exp_count,
  input  logic                     start,
  commit_checker_if.slave          rbus,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   matched,
  output logic [$clog2(DEPTH)-1:0] fail_index,
  output logic [3:0]               fail_mask,
  output logic [XLEN-1:0]          fail_got,
  output logic [XLEN-1:0]          fail_exp
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [TW-1:0] idle_cnt;
  logic [CW-1:0] count_clamped;
  logic [CW-1:0] matched_inc;
  trace_entry_t  load_entry;
  trace_entry_t  exp_e;
  logic [3:0]    diff;

  assign load_entry = '{pc: load_pc, rwe: load_rwe, rd: load_rd, wdata: load_wdata};

  trace_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we     (load_we && (state != RUN)),
    .waddr  (load_addr),
    .wentry (load_entry),
    .raddr  (matched[AW-1:0]),
    .rentry (exp_e)
  );

  assign count_clamped = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
  assign matched_inc   = matched + CW'(1);

  // rd/wdata only matter when the expected instruction writes a register,
  // unless STRICT asks for them to be checked regardless.
  always_comb begin
    diff           = '0;
    diff[FM_PC]    = CHECK_PC && (rbus.retire_pc != exp_e.pc);
    diff[FM_WE]    = (rbus.retire_we != exp_e.rwe);
    diff[FM_RD]    = (exp_e.rwe || STRICT) && (rbus.retire_rd != exp_e.rd);
    diff[FM_WDATA] = (exp_e.rwe || STRICT) && (rbus.retire_wdata != exp_e.wdata);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      idle_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      matched    <= '0;
      fail_index <= '0;
      fail_mask  <= '0;
      fail_got   <= '0;
      fail_exp   <= '0;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            count      <= count_clamped;
            matched    <= '0;
            idle_cnt   <= '0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            fail_index <= '0;
            fail_mask  <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
            if (count_clamped == '0) begin
              state <= PASS;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (rbus.retire_valid) begin
            idle_cnt <= '0;
            if (diff == '0) begin
              matched <= matched_inc;
              if (matched_inc == count) begin
                state <= PASS;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
              end
            end else begin
              state      <= FAIL;
              busy       <= 1'b0;
              done       <= 1'b1;
              fail       <= 1'b1;
              fail_index <= matched[AW-1:0];
              fail_mask  <= diff;
              fail_got   <= rbus.retire_wdata;
              fail_exp   <= exp_e.wdata;
            end
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            // This idle edge is the TIMEOUT-th in a row.
            state      <= FAIL;
            busy       <= 1'b0;
            done       <= 1'b1;
            fail       <= 1'b1;
            timeout    <= 1'b1;
            fail_index <= matched[AW-1:0];
            fail_mask  <= '0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_checker.sv
// Bench for commit_checker: two instances (STRICT=0 / STRICT=1, DEPTH=8,
// TIMEOUT=4) share load/start stimulus and see identical retire traffic.
module tb_commit_checker;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic [3:0]  matched;
    logic [2:0]  idx;
    logic [3:0]  mask;
    logic [31:0] got;
    logic [31:0] exp;
    logic [1:0]  done_at;   // retire number (1..3) whose edge raises done
  } result_t;

  typedef struct packed {
    ent_t    r0;
    ent_t    r1;
    ent_t    r2;
    result_t res0;          // expectation for STRICT=0 instance
    result_t res1;          // expectation for STRICT=1 instance
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_we = 1'b0;
  logic [2:0]  load_addr = '0;
  logic [31:0] load_pc = '0;
  logic [4:0]  load_rd = '0;
  logic [31:0] load_wdata = '0;
  logic        load_rwe = 1'b0;
  logic [3:0]  exp_count = '0;
  logic        start = 1'b0;

  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic        fail [2];
  logic        timeout [2];
  logic [3:0]  matched [2];
  logic [2:0]  fail_index [2];
  logic [3:0]  fail_mask [2];
  logic [31:0] fail_got [2];
  logic [31:0] fail_exp [2];

  int unsigned total = 0;
  int unsigned bad = 0;
  result_t     sb [$];

  commit_checker_if #(.XLEN(32)) rif0 ();
  commit_checker_if #(.XLEN(32)) rif1 ();

  commit_checker #(.XLEN(32), .DEPTH(8), .TIMEOUT(4), .STRICT(1'b0), .CHECK_PC(1'b1)) dut0 (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_pc(load_pc),
    .load_rd(load_rd), .load_wdata(load_wdata), .load_rwe(load_rwe), .exp_count(exp_count),
    .start(start), .rbus(rif0), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
    .timeout(timeout[0]), .matched(matched[0]), .fail_index(fail_index[0]),
    .fail_mask(fail_mask[0]), .fail_got(fail_got[0]), .fail_exp(fail_exp[0])
  );

  commit_checker #(.XLEN(32), .DEPTH(8), .TIMEOUT(4), .STRICT(1'b1), .CHECK_PC(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_pc(load_pc),
    .load_rd(load_rd), .load_wdata(load_wdata), .load_rwe(load_rwe), .exp_count(exp_count),
    .start(start), .rbus(rif1), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
    .timeout(timeout[1]), .matched(matched[1]), .fail_index(fail_index[1]),
    .fail_mask(fail_mask[1]), .fail_got(fail_got[1]), .fail_exp(fail_exp[1])
  );

  initial forever #5 clk = ~clk;

  function automatic ent_t mk_ent(logic [31:0] pc, logic we, logic [4:0] rd, logic [31:0] wdata);
    mk_ent = '{pc: pc, we: we, rd: rd, wdata: wdata};
  endfunction

  function automatic result_t mk_res(logic p, logic f, logic [3:0] m, logic [2:0] idx,
                                     logic [3:0] mask, logic [31:0] got, logic [31:0] exp,
                                     logic [1:0] done_at);
    mk_res = '{pass: p, fail: f, matched: m, idx: idx, mask: mask, got: got, exp: exp,
               done_at: done_at};
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=0x%0h expected=0x%0h", name, k, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_retire(input logic v, input ent_t e);
    rif0.retire_valid = v; rif0.retire_pc = e.pc; rif0.retire_we = e.we;
    rif0.retire_rd = e.rd; rif0.retire_wdata = e.wdata;
    rif1.retire_valid = v; rif1.retire_pc = e.pc; rif1.retire_we = e.we;
    rif1.retire_rd = e.rd; rif1.retire_wdata = e.wdata;
  endtask

  task automatic load_entry(input logic [2:0] a, input ent_t e);
    load_we = 1'b1; load_addr = a; load_pc = e.pc; load_rwe = e.we;
    load_rd = e.rd; load_wdata = e.wdata;
    step();
    load_we = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] n);
    exp_count = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_busy"}, k, 32'(busy[k]), 32'd0);
      check({tag, "_done"}, k, 32'(done[k]), 32'd0);
      check({tag, "_pass"}, k, 32'(pass[k]), 32'd0);
      check({tag, "_fail"}, k, 32'(fail[k]), 32'd0);
      check({tag, "_timeout"}, k, 32'(timeout[k]), 32'd0);
      check({tag, "_matched"}, k, 32'(matched[k]), 32'd0);
      check({tag, "_fidx"}, k, 32'(fail_index[k]), 32'd0);
      check({tag, "_fmask"}, k, 32'(fail_mask[k]), 32'd0);
      check({tag, "_fgot"}, k, fail_got[k], 32'd0);
      check({tag, "_fexp"}, k, fail_exp[k], 32'd0);
    end
  endtask

  initial begin
    ent_t    e0, e1, e2;
    ent_t    rs [3];
    ent_t    big [8];
    vec_t    vecs [5];
    result_t r;

    e0 = mk_ent(32'h0, 1'b1, 5'd1, 32'h3E8);
    e1 = mk_ent(32'h4, 1'b1, 5'd2, 32'h3C0);
    e2 = mk_ent(32'h8, 1'b0, 5'd8, 32'h8);

    vecs[0] = '{r0: e0, r1: e1, r2: e2,
                res0: mk_res(1, 0, 3, 0, 4'b0000, 0, 0, 3),
                res1: mk_res(1, 0, 3, 0, 4'b0000, 0, 0, 3)};
    vecs[1] = '{r0: e0, r1: mk_ent(32'h4, 1'b1, 5'd2, 32'h3C1), r2: e2,
                res0: mk_res(0, 1, 1, 1, 4'b1000, 32'h3C1, 32'h3C0, 2),
                res1: mk_res(0, 1, 1, 1, 4'b1000, 32'h3C1, 32'h3C0, 2)};
    vecs[2] = '{r0: e0, r1: e1, r2: mk_ent(32'h8, 1'b0, 5'd0, 32'h0),
                res0: mk_res(1, 0, 3, 0, 4'b0000, 0, 0, 3),
                res1: mk_res(0, 1, 2, 2, 4'b1100, 32'h0, 32'h8, 3)};
    vecs[3] = '{r0: mk_ent(32'h100, 1'b1, 5'd1, 32'h3E8), r1: e1, r2: e2,
                res0: mk_res(0, 1, 0, 0, 4'b0001, 32'h3E8, 32'h3E8, 1),
                res1: mk_res(0, 1, 0, 0, 4'b0001, 32'h3E8, 32'h3E8, 1)};
    vecs[4] = '{r0: mk_ent(32'h0, 1'b0, 5'd1, 32'h3E8), r1: e1, r2: e2,
                res0: mk_res(0, 1, 0, 0, 4'b0010, 32'h3E8, 32'h3E8, 1),
                res1: mk_res(0, 1, 0, 0, 4'b0010, 32'h3E8, 32'h3E8, 1)};

    drive_retire(1'b0, mk_ent(0, 0, 0, 0));

    // Reset state.
    #12;
    check_all_zero("reset");
    #1 rst = 1'b1;
    step();

    load_entry(3'd0, e0);
    load_entry(3'd1, e1);
    load_entry(3'd2, e2);

    // Table-driven three-retire runs.
    for (int v = 0; v < 5; v++) begin
      sb.push_back(vecs[v].res0);
      sb.push_back(vecs[v].res1);
      rs[0] = vecs[v].r0; rs[1] = vecs[v].r1; rs[2] = vecs[v].r2;
      start_run(4'd3);
      check($sformatf("v%0d_busy_start", v), 0, 32'(busy[0]), 32'd1);
      check($sformatf("v%0d_busy_start", v), 1, 32'(busy[1]), 32'd1);
      for (int i = 0; i < 3; i++) begin
        drive_retire(1'b1, rs[i]);
        step();
        check($sformatf("v%0d_done_r%0d", v, i + 1), 0, 32'(done[0]),
              32'((i + 1) >= int'(vecs[v].res0.done_at)));
        check($sformatf("v%0d_done_r%0d", v, i + 1), 1, 32'(done[1]),
              32'((i + 1) >= int'(vecs[v].res1.done_at)));
      end
      drive_retire(1'b0, rs[2]);
      for (int k = 0; k < 2; k++) begin
        r = sb.pop_front();
        check($sformatf("v%0d_pass", v), k, 32'(pass[k]), 32'(r.pass));
        check($sformatf("v%0d_fail", v), k, 32'(fail[k]), 32'(r.fail));
        check($sformatf("v%0d_busy", v), k, 32'(busy[k]), 32'd0);
        check($sformatf("v%0d_timeout", v), k, 32'(timeout[k]), 32'd0);
        check($sformatf("v%0d_matched", v), k, 32'(matched[k]), 32'(r.matched));
        check($sformatf("v%0d_fidx", v), k, 32'(fail_index[k]), 32'(r.idx));
        check($sformatf("v%0d_fmask", v), k, 32'(fail_mask[k]), 32'(r.mask));
        check($sformatf("v%0d_fgot", v), k, fail_got[k], r.got);
        check($sformatf("v%0d_fexp", v), k, fail_exp[k], r.exp);
      end
    end

    // Timeout: no retires after start; fires on the 4th idle RUN edge.
    start_run(4'd3);
    for (int i = 1; i <= 4; i++) begin
      step();
      for (int k = 0; k < 2; k++)
        check($sformatf("to_fail_e%0d", i), k, 32'(fail[k]), 32'(i == 4));
    end
    for (int k = 0; k < 2; k++) begin
      check("to_timeout", k, 32'(timeout[k]), 32'd1);
      check("to_done", k, 32'(done[k]), 32'd1);
      check("to_fidx", k, 32'(fail_index[k]), 32'd0);
      check("to_fmask", k, 32'(fail_mask[k]), 32'd0);
    end

    // Reset mid-run after two matches; a load attempted during RUN must be dropped.
    start_run(4'd3);
    drive_retire(1'b1, e0);
    step();
    drive_retire(1'b1, e1);
    load_we = 1'b1; load_addr = 3'd0; load_pc = 32'hDEAD; load_rwe = 1'b1;
    load_rd = 5'd1; load_wdata = 32'h3E8;
    step();
    load_we = 1'b0;
    drive_retire(1'b0, e1);
    check("mr_matched2", 0, 32'(matched[0]), 32'd2);
    #2 rst = 1'b0;
    #1;
    check_all_zero("midreset");
    rst = 1'b1;
    step();
    start_run(4'd3);
    rs[0] = e0; rs[1] = e1; rs[2] = e2;
    for (int i = 0; i < 3; i++) begin
      drive_retire(1'b1, rs[i]);
      step();
    end
    drive_retire(1'b0, e2);
    for (int k = 0; k < 2; k++) begin
      check("rerun_pass", k, 32'(pass[k]), 32'd1);
      check("rerun_matched", k, 32'(matched[k]), 32'd3);
    end

    // exp_count = 0 passes on the start edge.
    start_run(4'd0);
    for (int k = 0; k < 2; k++) begin
      check("cnt0_pass", k, 32'(pass[k]), 32'd1);
      check("cnt0_done", k, 32'(done[k]), 32'd1);
      check("cnt0_busy", k, 32'(busy[k]), 32'd0);
      check("cnt0_matched", k, 32'(matched[k]), 32'd0);
    end

    // exp_count = DEPTH+5 clamps to DEPTH; entry 0 is loaded in the start cycle.
    for (int i = 0; i < 8; i++)
      big[i] = mk_ent(32'(i * 4), 1'b1, 5'(i + 1), 32'(i * 3 + 7));
    for (int i = 1; i < 8; i++) load_entry(3'(i), big[i]);
    load_we = 1'b1; load_addr = 3'd0; load_pc = big[0].pc; load_rwe = big[0].we;
    load_rd = big[0].rd; load_wdata = big[0].wdata;
    start_run(4'd13);
    load_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_retire(1'b1, big[i]);
      step();
      if (i == 6) begin
        for (int k = 0; k < 2; k++) check("big_done_r7", k, 32'(done[k]), 32'd0);
      end
    end
    drive_retire(1'b0, big[7]);
    for (int k = 0; k < 2; k++) begin
      check("big_pass", k, 32'(pass[k]), 32'd1);
      check("big_fail", k, 32'(fail[k]), 32'd0);
      check("big_matched", k, 32'(matched[k]), 32'd8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
